// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS CPU memory-side blocks.
//   arb_state_t     : memory arbiter FSM states
//   WORD_ALIGN_MASK : clears byte-offset bits of a byte address
//   BE_WORD         : full-word byte enable used for instruction fetches
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        D_ACC,
        I_ACC,
        DONE
    } arb_state_t;

    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [3:0]  BE_WORD         = 4'hF;

    function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
        return byte_addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/mips_cpu_stall_timer.sv
// Bounded-stall timer for the memory arbiter.
// Counts consecutive waitrequest-high edges of one bus transaction and flags
// the edge on which the count reaches TIMEOUT_CYCLES.
//   clk, reset : clock, asynchronous active-high reset
//   clr_i      : clear the counter (between transactions)
//   inc_i      : this edge is a stall edge
//   timeout_o  : combinational; this stall edge brings the count to the limit
import mips_cpu_pkg::*;

module mips_cpu_stall_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 11
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic timeout_o
);

    localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);
    // Count value held before the final stall edge.
    localparam logic [CNT_W-1:0] LastStall =
        TimeoutEn ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;  // saturates, never wraps
        end
    end

    always_comb begin
        timeout_o = TimeoutEn && inc_i && (cnt_q >= LastStall);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mips_cpu_mem_arbiter.sv
// Memory arbiter: shares one Avalon-style bus between instruction fetch
// (read-only) and data load/store. Data has fixed priority over fetch.
//   clk, reset                : clock, asynchronous active-high reset
//   i_req/i_addr              : fetch request in; i_ack/i_rdata out
//   d_req/d_we/d_addr/d_wdata/d_be : data request in; d_ack/d_rdata out
//   err                       : pulses with an ack when that access timed out
//   address/read/write/writedata/byteenable : bus master outputs
//   waitrequest/readdata      : bus slave inputs
// All outputs are registered.
import mips_cpu_pkg::*;

module mips_cpu_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 11
) (
    input  logic        clk,
    input  logic        reset,
    // fetch requester
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    // data requester
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        err,
    // memory bus
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    arb_state_t  state_q, state_d;
    logic [31:0] address_q, address_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [31:0] writedata_q, writedata_d;
    logic [3:0]  byteenable_q, byteenable_d;
    logic        i_ack_q, i_ack_d;
    logic        d_ack_q, d_ack_d;
    logic        err_q, err_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic in_access;
    logic timer_clr;
    logic timer_inc;
    logic timeout;

    assign in_access = (state_q == D_ACC) || (state_q == I_ACC);
    assign timer_clr = !in_access;
    assign timer_inc = in_access && waitrequest;

    mips_cpu_stall_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_stall_timer (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (timer_clr),
        .inc_i     (timer_inc),
        .timeout_o (timeout)
    );

    always_comb begin
        state_d      = state_q;
        address_d    = address_q;
        read_d       = read_q;
        write_d      = write_q;
        writedata_d  = writedata_q;
        byteenable_d = byteenable_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        // acks and err are single-cycle pulses
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        err_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (d_req) begin
                    address_d    = word_align(d_addr);
                    write_d      = d_we;
                    read_d       = !d_we;
                    writedata_d  = d_wdata;
                    byteenable_d = d_be;
                    state_d      = D_ACC;
                end else if (i_req) begin
                    address_d    = word_align(i_addr);
                    write_d      = 1'b0;
                    read_d       = 1'b1;
                    writedata_d  = '0;
                    byteenable_d = BE_WORD;
                    state_d      = I_ACC;
                end
            end

            D_ACC, I_ACC: begin
                if (!waitrequest) begin
                    if (state_q == D_ACC) begin
                        if (read_q) begin
                            d_rdata_d = readdata;
                        end
                        d_ack_d = 1'b1;
                    end else begin
                        i_rdata_d = readdata;
                        i_ack_d   = 1'b1;
                    end
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = DONE;
                end else if (timeout) begin
                    // Abandon the access; rdata keeps its previous value.
                    d_ack_d = (state_q == D_ACC);
                    i_ack_d = (state_q == I_ACC);
                    err_d   = 1'b1;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = DONE;
                end
            end

            // Requests are deliberately not sampled here so a requester that
            // still holds req during its ack cycle is not serviced twice.
            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            address_q    <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            writedata_q  <= '0;
            byteenable_q <= '0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            err_q        <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            read_q       <= read_d;
            write_q      <= write_d;
            writedata_q  <= writedata_d;
            byteenable_q <= byteenable_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
            err_q        <= err_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;
    assign i_ack      = i_ack_q;
    assign d_ack      = d_ack_q;
    assign err        = err_q;
    assign i_rdata    = i_rdata_q;
    assign d_rdata    = d_rdata_q;

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Directed test of mips_cpu_mem_arbiter with a stall timeout of 8 cycles.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_mips_cpu_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        err;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    int unsigned n_tests;
    int unsigned n_fail;

    mips_cpu_mem_arbiter #(
        .TIMEOUT_CYCLES (8),
        .CNT_W          (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_ack       (i_ack),
        .i_rdata     (i_rdata),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_be        (d_be),
        .d_ack       (d_ack),
        .d_rdata     (d_rdata),
        .err         (err),
        .address     (address),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .waitrequest (waitrequest),
        .readdata    (readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%08h, expected 'h%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned acks;
        n_tests     = 0;
        n_fail      = 0;
        reset       = 1'b1;
        i_req       = 1'b0;
        i_addr      = '0;
        d_req       = 1'b0;
        d_we        = 1'b0;
        d_addr      = '0;
        d_wdata     = '0;
        d_be        = '0;
        waitrequest = 1'b0;
        readdata    = '0;

        // ---------------- reset state
        tick();
        tick();
        check_val("rst_read",  32'(read), 32'd0);
        check_val("rst_write", 32'(write), 32'd0);
        check_val("rst_addr",  address, 32'h0);
        check_val("rst_acks",  32'({i_ack, d_ack, err}), 32'd0);
        reset = 1'b0;
        tick();

        // ---------------- zero-wait fetch
        i_req    = 1'b1;
        i_addr   = 32'hBFC0_0006;
        readdata = 32'h2402_000A;
        tick();  // cycle 1
        check_val("f_addr",  address, 32'hBFC0_0004);
        check_val("f_read",  32'(read), 32'd1);
        check_val("f_be",    32'(byteenable), 32'hF);
        check_val("f_ack_early", 32'(i_ack), 32'd0);
        tick();  // cycle 2
        check_val("f_ack",   32'(i_ack), 32'd1);
        check_val("f_rdata", i_rdata, 32'h2402_000A);
        check_val("f_err",   32'(err), 32'd0);
        check_val("f_read_dn", 32'(read), 32'd0);
        i_req = 1'b0;
        tick();
        check_val("f_ack_once", 32'(i_ack), 32'd0);

        // ---------------- collision: data first, then fetch
        d_req    = 1'b1;
        d_we     = 1'b0;
        d_addr   = 32'h0000_1002;
        d_be     = 4'hF;
        i_req    = 1'b1;
        i_addr   = 32'h0000_0100;
        readdata = 32'h1111_1111;
        tick();
        check_val("c_d_addr", address, 32'h0000_1000);
        check_val("c_d_rw",   32'({read, write}), 32'b10);
        tick();
        check_val("c_d_acks", 32'({d_ack, i_ack}), 32'b10);
        check_val("c_d_rdata", d_rdata, 32'h1111_1111);
        d_req    = 1'b0;
        readdata = 32'h2222_2222;
        tick();  // IDLE
        check_val("c_idle", 32'({read, d_ack, i_ack}), 32'd0);
        tick();
        check_val("c_i_addr", address, 32'h0000_0100);
        check_val("c_i_read", 32'(read), 32'd1);
        tick();
        check_val("c_i_acks", 32'({d_ack, i_ack}), 32'b01);
        check_val("c_i_rdata", i_rdata, 32'h2222_2222);
        i_req = 1'b0;
        tick();

        // ---------------- stalled write, 3 wait cycles
        d_req       = 1'b1;
        d_we        = 1'b1;
        d_addr      = 32'h0000_2001;
        d_be        = 4'b0011;
        d_wdata     = 32'hDEAD_BEEF;
        waitrequest = 1'b1;
        tick();  // cycle 1
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("w_wr%0d", k), 32'({write, read}), 32'b10);
            check_val($sformatf("w_addr%0d", k), address, 32'h0000_2000);
            check_val($sformatf("w_wd%0d", k), writedata, 32'hDEAD_BEEF);
            check_val($sformatf("w_be%0d", k), 32'(byteenable), 32'h3);
            check_val($sformatf("w_noack%0d", k), 32'(d_ack), 32'd0);
            if (k == 1) d_wdata = 32'h0;  // not re-sampled while pending
            if (k == 3) waitrequest = 1'b0;
            tick();
        end
        check_val("w_ack",   32'(d_ack), 32'd1);
        check_val("w_err",   32'(err), 32'd0);
        check_val("w_off",   32'(write), 32'd0);
        check_val("w_rdata", d_rdata, 32'h1111_1111);
        d_req = 1'b0;
        d_we  = 1'b0;
        tick();

        // ---------------- timeout after 8 stall cycles
        d_req       = 1'b1;
        d_we        = 1'b0;
        d_addr      = 32'h0000_3000;
        waitrequest = 1'b1;
        readdata    = 32'h3333_3333;
        tick();  // cycle 1
        for (int k = 1; k <= 8; k++) begin
            check_val($sformatf("t_read%0d", k), 32'({read, d_ack}), 32'b10);
            tick();
        end
        check_val("t_read_off", 32'(read), 32'd0);
        check_val("t_ack",      32'(d_ack), 32'd1);
        check_val("t_err",      32'(err), 32'd1);
        check_val("t_rdata",    d_rdata, 32'h1111_1111);
        d_req       = 1'b0;
        waitrequest = 1'b0;
        tick();
        check_val("t_idle", 32'({read, d_ack, err}), 32'd0);

        // ---------------- reset mid-access
        i_req       = 1'b1;
        i_addr      = 32'h0000_0040;
        waitrequest = 1'b1;
        tick();
        tick();
        check_val("r_read_pre", 32'(read), 32'd1);
        #2;
        reset = 1'b1;
        #1;  // no clock edge since reset rose
        check_val("r_read",  32'(read), 32'd0);
        check_val("r_addr",  address, 32'h0);
        check_val("r_be",    32'(byteenable), 32'h0);
        check_val("r_rdata", i_rdata, 32'h0);
        check_val("r_acks",  32'({i_ack, d_ack, err}), 32'd0);
        i_req = 1'b0;
        tick();
        reset       = 1'b0;
        waitrequest = 1'b0;
        tick();
        tick();
        check_val("r_no_ack", 32'({i_ack, read}), 32'd0);
        i_req    = 1'b1;
        i_addr   = 32'h0000_0080;
        readdata = 32'h0000_0055;
        tick();
        check_val("r2_addr", address, 32'h0000_0080);
        check_val("r2_read", 32'(read), 32'd1);
        tick();
        check_val("r2_ack",   32'(i_ack), 32'd1);
        check_val("r2_rdata", i_rdata, 32'h0000_0055);
        i_req = 1'b0;
        tick();

        // ---------------- back-to-back fetches with i_req held
        // Expected read: 1 (c1), 0 (DONE c2), 0 (IDLE c3), 1 (c4), ...
        i_req    = 1'b1;
        i_addr   = 32'h0000_0200;
        readdata = 32'h0000_0066;
        acks     = 0;
        tick();  // cycle 1
        check_val("b_read1", 32'(read), 32'd1);
        tick();  // cycle 2
        check_val("b_ack1", 32'({i_ack, read}), 32'b10);
        acks += i_ack;
        i_addr   = 32'h0000_0204;
        readdata = 32'h0000_0077;
        tick();  // cycle 3
        check_val("b_idle", 32'({i_ack, read}), 32'b00);
        acks += i_ack;
        tick();  // cycle 4
        check_val("b_read2", 32'(read), 32'd1);
        check_val("b_addr2", address, 32'h0000_0204);
        acks += i_ack;
        tick();  // cycle 5
        check_val("b_rdata2", i_rdata, 32'h0000_0077);
        acks += i_ack;
        i_req = 1'b0;
        tick();
        acks += i_ack;
        check_val("b_ack_cnt", acks, 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
